// File: rtl/uart_io_ctrl_if.sv
// Bus bundle between the DataMem UART registers, the UART core
// and the controller that sequences them.
interface uart_io_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              tx_wr;
    logic [DATA_W-1:0] tx_wdata;
    logic              rx_rd;
    logic [DATA_W-1:0] rx_rdata;
    logic [1:0]        irq_en;
    logic              clr_ovr;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_empty;
    logic              rx_overrun;
    logic [DATA_W-1:0] UART_TXD;
    logic              TX_EN;
    logic              TX_STATUS;
    logic [DATA_W-1:0] UART_RXD;
    logic              RX_EFF;
    logic              RX_READ;
    logic              interrupt;

    modport master (
        output tx_wr, tx_wdata, rx_rd, irq_en, clr_ovr,
        output TX_STATUS, UART_RXD, RX_EFF,
        input  rx_rdata, tx_full, tx_empty, rx_empty, rx_overrun,
        input  UART_TXD, TX_EN, RX_READ, interrupt
    );

    modport slave (
        input  tx_wr, tx_wdata, rx_rd, irq_en, clr_ovr,
        input  TX_STATUS, UART_RXD, RX_EFF,
        output rx_rdata, tx_full, tx_empty, rx_empty, rx_overrun,
        output UART_TXD, TX_EN, RX_READ, interrupt
    );
endinterface

// File: rtl/uart_io_ctrl.sv
// UART sequencer: TX FIFO + TX_EN/TX_STATUS handshake,
// RX_EFF/RX_READ capture into an RX FIFO, level interrupt.
module uart_io_ctrl #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    uart_io_ctrl_if.slave bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_MAX = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_MAX = (RX_AW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_t;

    tx_state_t tx_state;
    rx_state_t rx_state;

    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr;
    logic [TX_AW-1:0]  tx_rptr;
    logic [TX_AW:0]    tx_cnt;

    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wptr;
    logic [RX_AW-1:0]  rx_rptr;
    logic [RX_AW:0]    rx_cnt;

    logic [DATA_W-1:0] txd_q;
    logic              tx_en_q;
    logic              rx_read_q;
    logic              ovr_q;
    logic              irq_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic rx_cap, ovr_set;

    assign tx_full  = (tx_cnt == TX_MAX);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == RX_MAX);
    assign rx_empty = (rx_cnt == '0);

    // START is only entered with a non-empty FIFO, so its pop is always legal
    assign tx_pop  = (tx_state == TX_START);
    assign tx_push = bus.tx_wr && (!tx_full || tx_pop);
    assign rx_pop  = bus.rx_rd && !rx_empty;
    assign rx_cap  = (rx_state == RX_IDLE) && bus.RX_EFF;
    assign rx_push = rx_cap && (!rx_full || rx_pop);
    assign ovr_set = rx_cap && !rx_push;

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= bus.tx_wdata;
        if (rx_push) rx_mem[rx_wptr] <= bus.UART_RXD;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // TX sequencer: launch one byte, then track the transmitter busy/idle cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            txd_q    <= '0;
            tx_en_q  <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_empty && bus.TX_STATUS) tx_state <= TX_START;
                end
                TX_START: begin
                    txd_q    <= tx_mem[tx_rptr];
                    tx_en_q  <= 1'b1;
                    tx_state <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (!bus.TX_STATUS) tx_state <= TX_WAIT_DONE;
                end
                TX_WAIT_DONE: begin
                    if (bus.TX_STATUS) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX capture: acknowledge each byte once, even when it must be dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            rx_read_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_read_q <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (bus.RX_EFF) begin
                        rx_read_q <= 1'b1;
                        rx_state  <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!bus.RX_EFF) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
            if (ovr_set)          ovr_q <= 1'b1;
            else if (bus.clr_ovr) ovr_q <= 1'b0;
        end
    end

    // Level interrupt, registered from the current FIFO/FSM status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (bus.irq_en[0] && !rx_empty) ||
                     (bus.irq_en[1] && tx_empty && (tx_state == TX_IDLE));
        end
    end

    assign bus.rx_rdata   = rx_empty ? '0 : rx_mem[rx_rptr];
    assign bus.tx_full    = tx_full;
    assign bus.tx_empty   = tx_empty;
    assign bus.rx_empty   = rx_empty;
    assign bus.rx_overrun = ovr_q;
    assign bus.UART_TXD   = txd_q;
    assign bus.TX_EN      = tx_en_q;
    assign bus.RX_READ    = rx_read_q;
    assign bus.interrupt  = irq_q;
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Bench for uart_io_ctrl: RX vector table, directed TX/reset
// sequences, and random traffic against a queue-based model.
module tb_uart_io_ctrl;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_io_ctrl_if #(.DATA_W(8)) bus ();

    uart_io_ctrl #(
        .DATA_W  (8),
        .TX_DEPTH(DEPTH),
        .RX_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       eff;
        logic [7:0] rxd;
        logic       rd;
        logic       clr;
        logic [1:0] ien;
        logic       read;
        logic       empty;
        logic [7:0] data;
        logic       ovr;
        logic       irq;
    } vec_t;

    vec_t vt [31];

    // reference model state
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic       m_ovr;
    logic       prev_eff;
    logic [1:0] rien;
    int         cyc;
    int         last_en;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tx_wr     = 1'b0;
        bus.tx_wdata  = 8'h00;
        bus.rx_rd     = 1'b0;
        bus.irq_en    = 2'b00;
        bus.clr_ovr   = 1'b0;
        bus.TX_STATUS = 1'b1;
        bus.UART_RXD  = 8'h00;
        bus.RX_EFF    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_tx_en(input int max, output int n,
                              output logic [7:0] d);
        n = 0;
        while (bus.TX_EN !== 1'b1 && n < max) begin
            step();
            n++;
        end
        d = bus.UART_TXD;
    endtask

    task automatic rand_cycle(input bit allow_wr);
        logic       wr, rd, clr, eff, cap, popped, rx_pop;
        logic       rx_full_pre, tx_full_pre, exp_irq, set;
        logic [7:0] wd, rxd, head;
        wr  = allow_wr && ($urandom_range(0, 2) == 0);
        wd  = 8'($urandom);
        rd  = ($urandom_range(0, 3) == 0);
        clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0)
            rien = {1'b0, 1'($urandom_range(0, 1))};
        if (prev_eff) eff = ($urandom_range(0, 2) == 0);
        else          eff = ($urandom_range(0, 1) == 0);
        bus.tx_wr     = wr;
        bus.tx_wdata  = wd;
        bus.rx_rd     = rd;
        bus.clr_ovr   = clr;
        bus.irq_en    = rien;
        bus.TX_STATUS = ($urandom_range(0, 2) != 0);
        if (eff && !prev_eff) bus.UART_RXD = 8'($urandom);
        bus.RX_EFF    = eff;
        rxd         = bus.UART_RXD;
        cap         = eff && !prev_eff;
        exp_irq     = rien[0] && (rxq.size() != 0);
        rx_full_pre = (rxq.size() == DEPTH);
        tx_full_pre = (txq.size() == DEPTH);
        set         = 1'b0;
        step();
        cyc++;
        popped = bus.TX_EN;
        if (popped) begin
            chk("rnd_tx_gap", 32'(cyc - last_en >= 4), 1);
            last_en = cyc;
            chk("rnd_tx_nonempty", 32'(txq.size() != 0), 1);
            if (txq.size() != 0) begin
                head = txq.pop_front();
                chk("rnd_tx_data", bus.UART_TXD, head);
            end
        end
        if (wr && (!tx_full_pre || popped)) txq.push_back(wd);
        rx_pop = rd && (rxq.size() != 0);
        if (rx_pop) void'(rxq.pop_front());
        if (cap) begin
            if (!rx_full_pre || rx_pop) rxq.push_back(rxd);
            else                        set = 1'b1;
        end
        if (set)      m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        prev_eff = eff;
        chk("rnd_rx_read", bus.RX_READ, cap);
        chk("rnd_tx_empty", bus.tx_empty, 32'(txq.size() == 0));
        chk("rnd_tx_full", bus.tx_full, 32'(txq.size() == DEPTH));
        chk("rnd_rx_empty", bus.rx_empty, 32'(rxq.size() == 0));
        chk("rnd_rx_rdata", bus.rx_rdata,
            (rxq.size() == 0) ? 32'h0 : 32'(rxq[0]));
        chk("rnd_overrun", bus.rx_overrun, m_ovr);
        chk("rnd_irq", bus.interrupt, exp_irq);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n, pulses;
        logic [7:0] d;

        // eff rxd rd clr ien | read empty data ovr irq
        vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[11] = '{1'b1, 8'h33, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[13] = '{1'b1, 8'h44, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[15] = '{1'b1, 8'h55, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1};
        vt[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
        vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[18] = '{1'b1, 8'h66, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
        vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0};
        vt[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0};
        vt[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[24] = '{1'b1, 8'h77, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[25] = '{1'b1, 8'h77, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[26] = '{1'b1, 8'h77, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[27] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[28] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[29] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[30] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        // reset values, before any clock edge
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("rst_tx_empty", bus.tx_empty, 1);
        chk("rst_rx_empty", bus.rx_empty, 1);
        chk("rst_tx_full", bus.tx_full, 0);
        chk("rst_overrun", bus.rx_overrun, 0);
        chk("rst_rdata", bus.rx_rdata, 0);
        chk("rst_txd", bus.UART_TXD, 0);
        chk("rst_tx_en", bus.TX_EN, 0);
        chk("rst_rx_read", bus.RX_READ, 0);
        chk("rst_irq", bus.interrupt, 0);
        do_reset();

        // RX ordering, overrun, clear, ACK hold, RX/TX interrupt levels
        for (int i = 0; i < 31; i++) begin
            bus.RX_EFF   = vt[i].eff;
            bus.UART_RXD = vt[i].rxd;
            bus.rx_rd    = vt[i].rd;
            bus.clr_ovr  = vt[i].clr;
            bus.irq_en   = vt[i].ien;
            step();
            chk($sformatf("vec%0d_rx_read", i), bus.RX_READ, vt[i].read);
            chk($sformatf("vec%0d_rx_empty", i), bus.rx_empty, vt[i].empty);
            chk($sformatf("vec%0d_rx_rdata", i), bus.rx_rdata, vt[i].data);
            chk($sformatf("vec%0d_overrun", i), bus.rx_overrun, vt[i].ovr);
            chk($sformatf("vec%0d_irq", i), bus.interrupt, vt[i].irq);
        end

        // single TX byte, exact latency and pulse width
        do_reset();
        bus.tx_wr    = 1'b1;
        bus.tx_wdata = 8'hCC;
        step();
        bus.tx_wr = 1'b0;
        chk("t1_not_empty", bus.tx_empty, 0);
        chk("t1_en_e0", bus.TX_EN, 0);
        step();
        chk("t1_en_e1", bus.TX_EN, 0);
        step();
        chk("t1_en_e2", bus.TX_EN, 1);
        chk("t1_txd", bus.UART_TXD, 8'hCC);
        chk("t1_empty", bus.tx_empty, 1);
        step();
        chk("t1_en_width", bus.TX_EN, 0);
        pulses = 0;
        bus.TX_STATUS = 1'b0;
        repeat (10) begin step(); pulses += int'(bus.TX_EN); end
        bus.TX_STATUS = 1'b1;
        repeat (10) begin step(); pulses += int'(bus.TX_EN); end
        chk("t1_no_more_en", pulses, 0);
        chk("t1_empty_end", bus.tx_empty, 1);
        chk("t1_txd_hold", bus.UART_TXD, 8'hCC);

        // TX burst into a stalled transmitter, fifth byte dropped
        do_reset();
        bus.TX_STATUS = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.tx_wr    = 1'b1;
            bus.tx_wdata = 8'(i);
            step();
            if (i == 3) chk("t2_not_full3", bus.tx_full, 0);
            if (i == 4) chk("t2_full4", bus.tx_full, 1);
        end
        bus.tx_wr = 1'b0;
        step();
        chk("t2_full_after5", bus.tx_full, 1);
        bus.TX_STATUS = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_tx_en(12, n, d);
            chk($sformatf("t2_en%0d", k), bus.TX_EN, 1);
            chk($sformatf("t2_order%0d", k), d, k);
            bus.TX_STATUS = 1'b0;
            step();
            step();
            bus.TX_STATUS = 1'b1;
            step();
        end
        pulses = 0;
        repeat (20) begin step(); pulses += int'(bus.TX_EN); end
        chk("t2_no_fifth", pulses, 0);
        chk("t2_empty", bus.tx_empty, 1);

        // TX-drained interrupt follows the FSM back to IDLE
        do_reset();
        bus.irq_en = 2'b10;
        step();
        chk("t5_idle_irq", bus.interrupt, 1);
        bus.tx_wr    = 1'b1;
        bus.tx_wdata = 8'h42;
        step();
        bus.tx_wr = 1'b0;
        wait_tx_en(10, n, d);
        chk("t5_en", bus.TX_EN, 1);
        chk("t5_irq_start", bus.interrupt, 0);
        bus.TX_STATUS = 1'b0;
        step();
        step();
        chk("t5_irq_busy", bus.interrupt, 0);
        bus.TX_STATUS = 1'b1;
        step();
        chk("t5_irq_done", bus.interrupt, 0);
        step();
        chk("t5_irq_drained", bus.interrupt, 1);

        // asynchronous reset in WAIT_BUSY with two bytes queued
        do_reset();
        bus.tx_wr    = 1'b1;
        bus.tx_wdata = 8'hAA;
        step();
        bus.tx_wdata = 8'hBB;
        step();
        bus.tx_wdata = 8'hCD;
        bus.RX_EFF   = 1'b1;
        bus.UART_RXD = 8'h3C;
        step();
        chk("t6_en", bus.TX_EN, 1);
        chk("t6_txd", bus.UART_TXD, 8'hAA);
        chk("t6_rx_read", bus.RX_READ, 1);
        chk("t6_tx_full", bus.tx_full, 0);
        reset = 1'b1;
        #1;
        chk("t6_async_en", bus.TX_EN, 0);
        chk("t6_async_rx_read", bus.RX_READ, 0);
        chk("t6_async_txd", bus.UART_TXD, 0);
        chk("t6_async_tx_empty", bus.tx_empty, 1);
        chk("t6_async_rx_empty", bus.rx_empty, 1);
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        pulses = 0;
        repeat (20) begin step(); pulses += int'(bus.TX_EN); end
        chk("t6_no_en_after", pulses, 0);
        bus.tx_wr    = 1'b1;
        bus.tx_wdata = 8'hDD;
        step();
        bus.tx_wr = 1'b0;
        wait_tx_en(10, n, d);
        chk("t6_new_latency", n, 2);
        chk("t6_new_txd", d, 8'hDD);

        // random traffic against the queue model
        do_reset();
        txq.delete();
        rxq.delete();
        m_ovr    = 1'b0;
        prev_eff = 1'b0;
        rien     = 2'b01;
        cyc      = 0;
        last_en  = -100;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 300; c++) rand_cycle(1'b0);
        chk("rnd_tx_drained", 32'(txq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
